// File: rtl/mem_bitwise_ctrl_if.sv
// Command/response handshake between a command source and mem_bitwise_ctrl.
// The source drives cmd_* and consumes rsp_*; the controller does the reverse.
interface mem_bitwise_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Command source side
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_bitwise_ctrl.sv
// Single-outstanding initiator for a 256 x 32 bitwise memory port.
// Executes READ, WRITE and read-modify-write SET/CLR/TGL commands and returns
// one response per command. Every memory-side and response output is a flop.
module mem_bitwise_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_bitwise_ctrl_if.slave cmd_if,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_c_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_mask,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_TGL   = 3'd4;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;

  state_t            state, state_n;
  logic [2:0]        op_q, op_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [DATA_W-1:0] wr_data_n;
  logic [DATA_W-1:0] rsp_data_n;
  logic              rsp_err_n;
  logic              rsp_load;
  logic              accept;

  assign accept = (state == IDLE) && cmd_if.cmd_valid && cmd_if.cmd_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state decode and next values for the registered outputs.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    op_n       = op_q;
    addr_n     = addr_q;
    data_n     = data_q;
    wr_data_n  = '0;
    rsp_data_n = '0;
    rsp_err_n  = 1'b0;
    rsp_load   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          op_n   = cmd_if.cmd_op;
          addr_n = cmd_if.cmd_addr;
          data_n = cmd_if.cmd_data;
          case (cmd_if.cmd_op)
            OP_READ, OP_SET, OP_CLR, OP_TGL: state_n = RD;
            OP_WRITE: begin
              state_n   = WR;
              wr_data_n = cmd_if.cmd_data;
            end
            default: begin
              // Illegal op: answer immediately, never touch the memory.
              state_n   = RSP;
              rsp_load  = 1'b1;
              rsp_err_n = 1'b1;
            end
          endcase
        end
      end
      RD: state_n = CAP;
      CAP: begin
        // mem_rd_data holds the old word this cycle; the modify is folded in
        // here so the write data is already registered when WR starts.
        if (op_q == OP_READ) begin
          state_n    = RSP;
          rsp_load   = 1'b1;
          rsp_data_n = mem_rd_data;
        end else begin
          state_n = WR;
          case (op_q)
            OP_SET:  wr_data_n = mem_rd_data | data_q;
            OP_CLR:  wr_data_n = mem_rd_data & ~data_q;
            default: wr_data_n = mem_rd_data ^ data_q;
          endcase
        end
      end
      WR: begin
        state_n    = RSP;
        rsp_load   = 1'b1;
        rsp_data_n = mem_wr_data;
      end
      RSP: begin
        if (cmd_if.rsp_valid && cmd_if.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Command latch and registered outputs, all driven from the next state.
  // NOTE: every flop here, including the command latch, is cleared by the
  // async reset so nothing stale survives into the first command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q             <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      mem_addr         <= '0;
      mem_c_en         <= 1'b0;
      mem_wr           <= 1'b0;
      mem_mask         <= '0;
      mem_wr_data      <= '0;
      cmd_if.cmd_ready <= 1'b0;
      cmd_if.rsp_valid <= 1'b0;
      cmd_if.rsp_data  <= '0;
      cmd_if.rsp_err   <= 1'b0;
    end else begin
      op_q             <= op_n;
      addr_q           <= addr_n;
      data_q           <= data_n;
      mem_addr         <= addr_n;
      mem_c_en         <= (state_n == RD) || (state_n == WR);
      mem_wr           <= (state_n == WR);
      mem_mask         <= (state_n == WR) ? '1 : '0;
      mem_wr_data      <= (state_n == WR) ? wr_data_n : '0;
      cmd_if.cmd_ready <= (state_n == IDLE);
      // rsp_valid rises one cycle after entering RSP and drops on handshake.
      cmd_if.rsp_valid <= (state == RSP) && (state_n == RSP);
      if (rsp_load) begin
        cmd_if.rsp_data <= rsp_data_n;
        cmd_if.rsp_err  <= rsp_err_n;
      end
    end
  end

endmodule

// File: tb/tb_mem_bitwise_ctrl.sv
// Directed bench for mem_bitwise_ctrl with a behavioural 256 x 32 memory.
module tb_mem_bitwise_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_addr;
  logic        mem_c_en;
  logic        mem_wr;
  logic [31:0] mem_mask;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  mem_bitwise_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_bitwise_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_if      (bus.slave),
    .mem_addr    (mem_addr),
    .mem_c_en    (mem_c_en),
    .mem_wr      (mem_wr),
    .mem_mask    (mem_mask),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory model: masked write, read data valid the cycle after a read edge.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_c_en) begin
      if (mem_wr) mem[mem_addr] <= (mem[mem_addr] & ~mem_mask) | (mem_wr_data & mem_mask);
      else        mem_rd_data   <= mem[mem_addr];
    end
  end

  // Memory activity monitor, sampled mid-cycle.
  int          rd_cnt, wr_cnt;
  logic [31:0] wr_mask_seen, wr_val_seen;
  always @(negedge clk) begin
    if (mem_c_en && !mem_wr) rd_cnt = rd_cnt + 1;
    if (mem_c_en && mem_wr) begin
      wr_cnt       = wr_cnt + 1;
      wr_mask_seen = mem_mask;
      wr_val_seen  = mem_wr_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Presents a command and returns #1 after the accepting edge.
  task automatic start_cmd(input logic [2:0] op, input logic [7:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready never seen for op %0d", op);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0; wr_mask_seen = '0; wr_val_seen = '0;
  endtask

  // Counts edges from acceptance until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.rsp_valid && lat < 20);
  endtask

  // Full command with rsp_ready already high; returns after the handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] data, output logic err,
                         output logic ready_after);
    start_cmd(op, a, d);
    wait_rsp(lat);
    data = bus.rsp_data; err = bus.rsp_err;
    @(posedge clk); #1;
    ready_after = bus.cmd_ready && !bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({mem_addr, mem_c_en, mem_wr, mem_mask, mem_wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_mem_outs: got %h/%b/%b/%h/%h want all 0", mem_addr, mem_c_en, mem_wr, mem_mask, mem_wr_data);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready} !== '0) begin
      n_fail++; $display("FAIL reset_rsp_outs: got v=%b d=%h e=%b rdy=%b want all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d; logic e, r;
    run_cmd(3'd1, 8'h10, 32'hDEADBEEF, lat, d, e, r);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency: got %0d want 2", lat); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_rsp_data: got %h want deadbeef", d); end
    n_checks++; if (wr_mask_seen !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL write_mask: got %h want ffffffff", wr_mask_seen); end
    n_checks++; if (rd_cnt !== 0 || wr_cnt !== 1) begin n_fail++; $display("FAIL write_access: got rd=%0d wr=%0d want rd=0 wr=1", rd_cnt, wr_cnt); end
    n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL write_handshake: got ready_after=%b want 1", r); end
    run_cmd(3'd0, 8'h10, 32'h0, lat, d, e, r);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", lat); end
    n_checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL read_rsp: got %h err=%b want deadbeef err=0", d, e); end
    n_checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin n_fail++; $display("FAIL read_access: got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_rmw_chain();
    logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd4};
    logic [31:0] opd [3] = '{32'hFF000000, 32'h000000F0, 32'hFFFFFFFF};
    logic [31:0] exp [3] = '{32'hFF00FFFF, 32'hFF00FF0F, 32'h00FF00F0};
    int lat; logic [31:0] d; logic e, r;
    for (int i = 0; i < 3; i++) begin
      run_cmd(ops[i], 8'hFF, opd[i], lat, d, e, r);
      n_checks++; if (d !== exp[i] || e !== 1'b0) begin n_fail++; $display("FAIL rmw%0d_rsp: got %h err=%b want %h err=0", i, d, e, exp[i]); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rmw%0d_latency: got %0d want 4", i, lat); end
      n_checks++; if (rd_cnt !== 1 || wr_cnt !== 1) begin n_fail++; $display("FAIL rmw%0d_access: got rd=%0d wr=%0d want 1/1", i, rd_cnt, wr_cnt); end
      n_checks++; if (wr_val_seen !== exp[i] || wr_mask_seen !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rmw%0d_wr: got %h mask %h want %h mask ffffffff", i, wr_val_seen, wr_mask_seen, exp[i]); end
    end
    run_cmd(3'd0, 8'hFF, 32'h0, lat, d, e, r);
    n_checks++; if (d !== 32'h00FF00F0) begin n_fail++; $display("FAIL rmw_readback: got %h want 00ff00f0", d); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic e, r;
    run_cmd(3'd6, 8'h33, 32'hA5A5A5A5, lat, d, e, r);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    n_checks++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL illegal_rsp: got err=%b data=%h want err=1 data=0", e, d); end
    n_checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin n_fail++; $display("FAIL illegal_access: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] d; logic e, r;
    bus.rsp_ready = 1'b0;
    start_cmd(3'd0, 8'hFF, 32'h0);
    wait_rsp(lat);
    n_checks++; if (lat !== 3 || bus.rsp_data !== 32'h00FF00F0) begin n_fail++; $display("FAIL bp_first_rsp: got lat=%0d data=%h want 3/00ff00f0", lat, bus.rsp_data); end
    @(negedge clk);
    bus.cmd_op = 3'd1; bus.cmd_addr = 8'h20; bus.cmd_data = 32'h12345678; bus.cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h00FF00F0 || bus.cmd_ready !== 1'b0 || mem_c_en !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall%0d: got v=%b d=%h rdy=%b cen=%b want 1/00ff00f0/0/0", c, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, mem_c_en);
      end
    end
    @(negedge clk); bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want 0/1", bus.rsp_valid, bus.cmd_ready); end
    n_checks++; if (mem[8'h20] === 32'h12345678) begin n_fail++; $display("FAIL bp_early_accept: got mem[20]=%h before acceptance, want untouched", mem[8'h20]); end
    start_cmd(3'd1, 8'h20, 32'h12345678);
    wait_rsp(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_next_latency: got %0d want 2", lat); end
    @(posedge clk); #1;
    run_cmd(3'd0, 8'h20, 32'h0, lat, d, e, r);
    n_checks++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL bp_next_readback: got %h want 12345678", d); end
  endtask

  task automatic test_reset_during_wr();
    int lat; logic [31:0] d; logic e, r; int seen;
    start_cmd(3'd2, 8'h40, 32'h0000000F);
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rstwr_in_wr: got mem_wr=%b want 1", mem_wr); end
    rst = 1'b1; #1;
    n_checks++;
    if ({mem_addr, mem_c_en, mem_wr, mem_mask, mem_wr_data, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready} !== '0) begin
      n_fail++; $display("FAIL rstwr_async_clear: got addr=%h cen=%b wr=%b mask=%h wd=%h v=%b rdy=%b want all 0", mem_addr, mem_c_en, mem_wr, mem_mask, mem_wr_data, bus.rsp_valid, bus.cmd_ready);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
    n_checks++; if (seen !== 0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstwr_no_rsp: got rsp cycles=%0d rdy=%b want 0/1", seen, bus.cmd_ready); end
    run_cmd(3'd0, 8'h10, 32'h0, lat, d, e, r);
    n_checks++; if (d !== 32'hDEADBEEF || lat !== 3) begin n_fail++; $display("FAIL rstwr_next_cmd: got %h lat=%0d want deadbeef 3", d, lat); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'hFF] = 32'h0000FFFF;
    rd_cnt = 0; wr_cnt = 0; wr_mask_seen = '0; wr_val_seen = '0;
    test_reset();
    test_write_read();
    test_rmw_chain();
    test_illegal();
    test_backpressure();
    test_reset_during_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
